// File: rtl/i2c_master_tx.sv
// rtl/i2c_master_tx.sv - single-master I2C write engine (START, addr+W, data bytes with ACK check, STOP)
//
// Ports:
//   sysclk, rst            : clock and synchronous active-high reset
//   start, addr            : begin a write to addr (accepted only when idle and not in the done cycle)
//   tx_data/valid/last     : byte stream in; tx_ready is high only while waiting for the next byte
//   busy, done, nak        : transfer status; nak is valid with done and holds until the next start
//   sda_in, scl_in         : synchronised bus levels
//   sda_oe, scl_oe         : 1 = pull the line low, 0 = release
module i2c_master_tx #(
    parameter int QTR_DIV = 250,
    parameter int CNT_W   = 16
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       nak,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] qcnt_q, qcnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             nak_q, nak_d;
    logic             tx_ready_q, tx_ready_d;
    logic             sda_oe_q, sda_oe_d;
    logic             scl_oe_q, scl_oe_d;

    logic timed, tick, hold, adv;

    assign timed = (state_q == S_START) || (state_q == S_BIT) ||
                   (state_q == S_ACK)   || (state_q == S_STOP);
    assign tick  = (qcnt_q == CNT_W'(QTR_DIV - 1));
    // While SCL is released but still seen low, a slave is stretching: freeze the quarter.
    assign hold  = !scl_in &&
                   ((((state_q == S_BIT) || (state_q == S_ACK)) && (qtr_q == 2'd2)) ||
                    ((state_q == S_STOP) && (qtr_q == 2'd1)));
    assign adv   = timed && tick && !hold;

    always_comb begin
        state_d  = state_q;
        qtr_d    = qtr_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        nak_d    = nak_q;
        qcnt_d   = '0;
        if (timed && !hold && !tick) begin
            qcnt_d = qcnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                // The done cycle still counts as busy for the purpose of start acceptance.
                if (start && !done_q) begin
                    shreg_d = {addr, 1'b0};
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    nak_d   = 1'b0;
                    qtr_d   = 2'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (adv) begin
                    if (qtr_q == 2'd1) begin
                        qtr_d    = 2'd0;
                        bitcnt_d = 3'd7;
                        state_d  = S_BIT;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (adv) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bitcnt_q == 3'd0) begin
                            state_d = S_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                if (adv) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (sda_in) begin
                            nak_d   = 1'b1;
                            state_d = S_STOP;
                        end else if (last_q) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_LOAD: begin
                if (tx_valid) begin
                    shreg_d  = tx_data;
                    last_d   = tx_last;
                    bitcnt_d = 3'd7;
                    qtr_d    = 2'd0;
                    state_d  = S_BIT;
                end
            end
            S_STOP: begin
                if (adv) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line drives are decoded from the next state so the registered pins line up with state_q.
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                sda_oe_d = 1'b1;
                scl_oe_d = (qtr_d == 2'd1);
            end
            S_BIT: begin
                sda_oe_d = ~shreg_d[bitcnt_d];
                scl_oe_d = ~qtr_d[1];
            end
            S_ACK: begin
                scl_oe_d = ~qtr_d[1];
            end
            S_LOAD: begin
                scl_oe_d = 1'b1;
            end
            S_STOP: begin
                scl_oe_d = (qtr_d == 2'd0);
                sda_oe_d = ~qtr_d[1];
            end
            default: begin
                sda_oe_d = 1'b0;
                scl_oe_d = 1'b0;
            end
        endcase
        tx_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            qtr_q      <= 2'd0;
            bitcnt_q   <= 3'd0;
            shreg_q    <= 8'd0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nak_q      <= 1'b0;
            tx_ready_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            qtr_q      <= qtr_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nak_q      <= nak_d;
            tx_ready_q <= tx_ready_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nak      = nak_q;
    assign sda_oe   = sda_oe_q;
    assign scl_oe   = scl_oe_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// tb/tb_i2c_master_tx.sv - directed self-checking bench for i2c_master_tx with bus monitor and ACK/stretch slave
module tb_i2c_master_tx;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = 7'h50;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, busy, done, nak, sda_oe, scl_oe;
    logic       sda_in, scl_in;
    logic       slave_sda = 1'b0;
    logic       stretch = 1'b0;

    assign sda_in = ~sda_oe & ~slave_sda;
    assign scl_in = ~scl_oe & ~stretch;

    i2c_master_tx #(.QTR_DIV(4), .CNT_W(4)) dut (
        .sysclk(sysclk), .rst(rst), .start(start), .addr(addr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .busy(busy), .done(done), .nak(nak),
        .sda_in(sda_in), .scl_in(scl_in), .sda_oe(sda_oe), .scl_oe(scl_oe)
    );

    always #5 sysclk = ~sysclk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Bus monitor and slave model state
    logic       prev_sda = 1'b1, prev_scl = 1'b1;
    logic [7:0] mon_sh = 8'h00;
    logic [7:0] mon_bytes[$];
    logic       mon_acks[$];
    int         mon_bitn = 0, mon_byte_idx = 0;
    int         n_start = 0, n_stop = 0, n_done = 0;
    logic       ack_addr = 1'b1, ack_data = 1'b1;
    logic [7:0] txq[$];
    int         hold_bad = 0;

    always @(negedge sysclk) begin
        logic s_now, c_now;
        s_now = sda_in;
        c_now = scl_in;
        if (prev_scl && c_now && prev_sda && !s_now) begin
            n_start++;
            mon_bitn = 0;
            mon_byte_idx = 0;
        end
        if (prev_scl && c_now && !prev_sda && s_now) n_stop++;
        if (!prev_scl && c_now) begin
            if (mon_bitn < 8) begin
                mon_sh = {mon_sh[6:0], s_now};
                mon_bitn++;
                if (mon_bitn == 8) mon_bytes.push_back(mon_sh);
            end else if (mon_bitn == 8) begin
                mon_acks.push_back(s_now);
                mon_bitn = 9;
            end
        end
        if (prev_scl && !c_now) begin
            if (mon_bitn == 8) begin
                slave_sda = (mon_byte_idx == 0) ? ack_addr : ack_data;
            end else if (mon_bitn == 9) begin
                slave_sda = 1'b0;
                mon_bitn = 0;
                mon_byte_idx++;
            end
        end
        if (done) n_done++;
        prev_sda = s_now;
        prev_scl = c_now;
    end

    task automatic clear_mon();
        mon_bytes.delete();
        mon_acks.delete();
        mon_bitn = 0;
        mon_byte_idx = 0;
        n_start = 0;
        n_stop = 0;
        n_done = 0;
        slave_sda = 1'b0;
        hold_bad = 0;
    endtask

    task automatic kick(input logic [6:0] a);
        addr = a;
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
    endtask

    task automatic feed(input int hold_idx, input int hold_cyc);
        for (int i = 0; i < txq.size(); i++) begin
            int t = 0;
            while (tx_ready !== 1'b1 && t < 5000) begin
                @(negedge sysclk);
                t++;
            end
            if (tx_ready !== 1'b1) return;
            if (i == hold_idx) begin
                repeat (hold_cyc) begin
                    @(negedge sysclk);
                    if (scl_oe !== 1'b1 || scl_in !== 1'b0 || tx_ready !== 1'b1) hold_bad++;
                end
            end
            tx_data = txq[i];
            tx_last = (i == txq.size() - 1);
            tx_valid = 1'b1;
            @(negedge sysclk);
            tx_valid = 1'b0;
            tx_last = 1'b0;
        end
    endtask

    task automatic wait_done(output int cyc, output logic saw_ready);
        int t = 0;
        cyc = 0;
        saw_ready = 1'b0;
        while (done !== 1'b1 && t < 5000) begin
            if (busy === 1'b1) cyc++;
            if (tx_ready === 1'b1) saw_ready = 1'b1;
            @(negedge sysclk);
            t++;
        end
    endtask

    task automatic stretch_bit3();
        int t = 0;
        while (!(mon_byte_idx == 1 && mon_bitn == 3 && scl_oe === 1'b1) && t < 5000) begin
            @(negedge sysclk);
            t++;
        end
        stretch = 1'b1;
        while (scl_oe === 1'b1 && t < 5000) begin
            @(negedge sysclk);
            t++;
        end
        repeat (30) @(negedge sysclk);
        stretch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        chk_cnt++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else pass_cnt++;
        chk_cnt++; if (scl_oe !== 1'b0) $display("FAIL reset_scl_oe: got %b want 0", scl_oe); else pass_cnt++;
        chk_cnt++; if ({busy, done, nak, tx_ready} !== 4'b0000)
            $display("FAIL reset_status: got busy/done/nak/ready=%b want 0000", {busy, done, nak, tx_ready}); else pass_cnt++;
        repeat (2) @(negedge sysclk);
    endtask

    task automatic test_single();
        int cyc; logic sr;
        clear_mon();
        ack_addr = 1'b1; ack_data = 1'b1;
        txq = '{8'hA5};
        kick(7'h50);
        fork
            feed(-1, 0);
            wait_done(cyc, sr);
        join
        repeat (10) @(negedge sysclk);
        chk_cnt++; if (mon_bytes.size() != 2) $display("FAIL single_nbytes: got %0d want 2", mon_bytes.size()); else pass_cnt++;
        chk_cnt++; if (mon_bytes.size() < 2 || mon_bytes[0] !== 8'hA0 || mon_bytes[1] !== 8'hA5)
            $display("FAIL single_bytes: got %p want A0,A5", mon_bytes); else pass_cnt++;
        chk_cnt++; if (mon_acks.size() != 2 || mon_acks[0] !== 1'b0 || mon_acks[1] !== 1'b0)
            $display("FAIL single_acks: got %p want 0,0", mon_acks); else pass_cnt++;
        chk_cnt++; if (n_start != 1 || n_stop != 1) $display("FAIL single_start_stop: got %0d/%0d want 1/1", n_start, n_stop); else pass_cnt++;
        chk_cnt++; if (n_done != 1) $display("FAIL single_done: got %0d want 1", n_done); else pass_cnt++;
        chk_cnt++; if (nak !== 1'b0) $display("FAIL single_nak: got %b want 0", nak); else pass_cnt++;
        chk_cnt++; if (cyc != 313) $display("FAIL single_busy_cycles: got %0d want 313", cyc); else pass_cnt++;
    endtask

    task automatic test_addr_nak();
        int cyc; logic sr;
        clear_mon();
        ack_addr = 1'b0; ack_data = 1'b1;
        kick(7'h50);
        wait_done(cyc, sr);
        repeat (10) @(negedge sysclk);
        chk_cnt++; if (mon_bytes.size() != 1 || mon_bytes[0] !== 8'hA0) $display("FAIL nak_bytes: got %p want A0", mon_bytes); else pass_cnt++;
        chk_cnt++; if (mon_acks.size() != 1 || mon_acks[0] !== 1'b1) $display("FAIL nak_ackbit: got %p want 1", mon_acks); else pass_cnt++;
        chk_cnt++; if (sr !== 1'b0) $display("FAIL nak_tx_ready: got %b want 0", sr); else pass_cnt++;
        chk_cnt++; if (cyc != 168) $display("FAIL nak_busy_cycles: got %0d want 168", cyc); else pass_cnt++;
        chk_cnt++; if (n_done != 1 || n_stop != 1) $display("FAIL nak_done_stop: got %0d/%0d want 1/1", n_done, n_stop); else pass_cnt++;
        chk_cnt++; if (nak !== 1'b1) $display("FAIL nak_held: got %b want 1", nak); else pass_cnt++;
        ack_addr = 1'b1;
    endtask

    task automatic test_stall();
        int cyc; logic sr;
        clear_mon();
        txq = '{8'h11, 8'h22, 8'h33};
        kick(7'h50);
        fork
            feed(1, 50);
            wait_done(cyc, sr);
        join
        repeat (10) @(negedge sysclk);
        chk_cnt++; if (mon_bytes.size() != 4 || mon_bytes[0] !== 8'hA0 || mon_bytes[1] !== 8'h11 ||
                       mon_bytes[2] !== 8'h22 || mon_bytes[3] !== 8'h33)
            $display("FAIL stall_bytes: got %p want A0,11,22,33", mon_bytes); else pass_cnt++;
        chk_cnt++; if (hold_bad != 0) $display("FAIL stall_scl_low: got %0d bad cycles want 0", hold_bad); else pass_cnt++;
        chk_cnt++; if (cyc != 653) $display("FAIL stall_busy_cycles: got %0d want 653", cyc); else pass_cnt++;
        chk_cnt++; if (n_done != 1 || nak !== 1'b0) $display("FAIL stall_done_nak: got %0d/%b want 1/0", n_done, nak); else pass_cnt++;
    endtask

    task automatic test_stretch();
        int cyc; logic sr;
        clear_mon();
        txq = '{8'hA5};
        kick(7'h50);
        fork
            feed(-1, 0);
            wait_done(cyc, sr);
            stretch_bit3();
        join
        repeat (10) @(negedge sysclk);
        chk_cnt++; if (mon_bytes.size() != 2 || mon_bytes[1] !== 8'hA5) $display("FAIL stretch_byte: got %p want A0,A5", mon_bytes); else pass_cnt++;
        chk_cnt++; if (cyc != 343) $display("FAIL stretch_busy_cycles: got %0d want 343", cyc); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc; logic sr;
        clear_mon();
        txq = '{8'hA5};
        kick(7'h50);
        feed(-1, 0);
        repeat (20) @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        chk_cnt++; if ({sda_oe, scl_oe, busy, tx_ready} !== 4'b0000)
            $display("FAIL rstmid_outputs: got sda/scl/busy/ready=%b want 0000", {sda_oe, scl_oe, busy, tx_ready}); else pass_cnt++;
        repeat (5) @(negedge sysclk);
        clear_mon();
        kick(7'h50);
        fork
            feed(-1, 0);
            wait_done(cyc, sr);
        join
        repeat (10) @(negedge sysclk);
        chk_cnt++; if (mon_bytes.size() != 2 || mon_bytes[0] !== 8'hA0 || mon_bytes[1] !== 8'hA5)
            $display("FAIL rstmid_after_bytes: got %p want A0,A5", mon_bytes); else pass_cnt++;
        chk_cnt++; if (cyc != 313 || n_done != 1) $display("FAIL rstmid_after_xfer: got cyc=%0d done=%0d want 313/1", cyc, n_done); else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        clear_mon();
        txq = '{8'h5A};
        kick(7'h50);
        fork
            feed(-1, 0);
            begin
                repeat (100) @(negedge sysclk);
                addr = 7'h33;
                start = 1'b1;
                @(negedge sysclk);
                start = 1'b0;
                addr = 7'h50;
            end
            begin
                int t = 0;
                while (done !== 1'b1 && t < 5000) begin
                    @(negedge sysclk);
                    t++;
                end
                start = 1'b1;
                @(negedge sysclk);
                start = 1'b0;
            end
        join
        repeat (20) @(negedge sysclk);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL ignore_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (n_start != 1 || n_stop != 1 || n_done != 1)
            $display("FAIL ignore_counts: got start/stop/done=%0d/%0d/%0d want 1/1/1", n_start, n_stop, n_done); else pass_cnt++;
        chk_cnt++; if (mon_bytes.size() != 2 || mon_bytes[0] !== 8'hA0 || mon_bytes[1] !== 8'h5A)
            $display("FAIL ignore_bytes: got %p want A0,5A", mon_bytes); else pass_cnt++;
    endtask

    initial begin
        @(negedge sysclk);
        test_reset();
        test_single();
        test_addr_nak();
        test_stall();
        test_stretch();
        test_reset_mid();
        test_start_ignored();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
